window_generator: RTL and testbench
===================================

WINDOW_GENERATOR -- requirements
Module: window_generator

Interface
REQ-001 Parameter: IMG_W, 8, pixels per image row (min 3).
REQ-002 Parameter: IMG_H, 8, rows per frame (min 3).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 pix_data  input  8  raster-order pixel, row-major, left to right.
REQ-006 pix_valid  input  1  pix_data valid.
REQ-007 pix_ready  output  1  block accepts pix_data this cycle.
REQ-008 win_data  output  8 x [0:2][0:2]  3x3 window feeding image_processor input_data.
REQ-009 win_valid  output  1  win_data valid, drives image_processor input_valid.
REQ-010 win_ready  input  1  downstream accepts, driven by image_processor input_ready.
REQ-011 frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-012 Pixel transfer occurs when pix_valid && pix_ready; window transfer occurs when win_valid && win_ready.
REQ-013 pix_ready SHALL equal !win_valid || win_ready, combinationally, with no other term.
REQ-014 Counters col (0..IMG_W-1) and row (0..IMG_H-1) SHALL advance only on pixel transfer; col wraps to 0 and row increments; at (IMG_H-1, IMG_W-1) both wrap to 0.
REQ-015 Two line buffers, each IMG_W deep, SHALL hold rows r-1 and r-2; a 3x3 shift register of pixels SHALL shift one column per pixel transfer.
REQ-016 State FILL: row < 2; windows are not emitted.
REQ-017 State RUN: row >= 2; a window is emitted on a pixel transfer only when col >= 2.
REQ-018 Transition FILL->RUN on the transfer that wraps row 1 to row 2; RUN->FILL on the frame's last pixel transfer.
REQ-019 Window orientation: win_data[0][*] = row r-2, [2][*] = row r; [*][0] = col c-2, [*][2] = col c; [2][2] = the just-accepted pixel.
REQ-020 Latency: win_valid SHALL rise in the cycle after the qualifying pixel transfer (1-cycle registered output).
REQ-021 While win_valid && !win_ready, win_data and win_valid SHALL hold stable and no pixel is accepted.
REQ-022 win_valid SHALL drop after a window transfer unless a new qualifying pixel transfers in the same cycle; back-to-back windows SHALL then sustain one per cycle.
REQ-023 Output count SHALL be (IMG_W-2)*(IMG_H-2) windows per frame; no edge padding; rows do not wrap into windows (col 0/1 never emit).
REQ-024 frame_done SHALL assert the cycle after the last-pixel transfer, for exactly one cycle, independent of win_ready.
REQ-025 Frames may be back to back with no idle cycles; line-buffer contents from the prior frame SHALL never appear in a window, because FILL suppresses output.

Reset
REQ-026 On rst_n low: win_valid=0, frame_done=0, col=0, row=0, state=FILL; pix_ready therefore 1.
REQ-027 Line-buffer RAM and the window shift register SHALL NOT be reset; win_data is don't-care while win_valid=0.
REQ-028 Reset mid-frame SHALL discard any pending window; the first pixel after deassertion is treated as (0,0).

Structure
REQ-029 Shared package img_pkg: PIX_W=8 constant, pixel_t, window_t (pixel_t [0:2][0:2]); image_processor and window_generator SHALL both import it.
REQ-030 One sub-module line_buffer (IMG_W-deep, 1 write/1 read per cycle, enable = pixel transfer), instantiated twice.

Verification (IMG_W=IMG_H=8, pixel value = row*8+col+1)
REQ-031 Stream one frame, win_ready=1 -> first win_data rows {1,2,3},{9,10,11},{17,18,19} one cycle after pixel 19 is accepted; 36 windows total; last window {46,47,48},{54,55,56},{62,63,64}.
REQ-032 Hold win_ready=0 for 5 cycles with win_valid=1 -> win_data stable, pix_ready=0, no pixel lost; the window sequence is identical to REQ-031.
REQ-033 Random pix_valid gaps (50%) -> identical 36-window sequence; frame_done is a single pulse after pixel 64.
REQ-034 Two frames back to back -> frame_done pulses twice; second frame's first window equals {1,2,3},{9,10,11},{17,18,19}, with no stale data.
REQ-035 Assert rst_n low after pixel 30, then restart the frame -> win_valid=0 during reset; the next 36 windows match REQ-031.
REQ-036 Connect to image_processor with config_select swept 0..3 -> 36 output_data results per config, with no handshake deadlock.

Source files
------------

// File: rtl/img_pkg.sv
// Shared pixel and window types for the image pipeline.
// Used by window_generator and image_processor.
package img_pkg;

    localparam int PIX_W = 8;

    typedef logic [PIX_W-1:0] pixel_t;
    typedef pixel_t [0:2][0:2] window_t;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } wg_state_t;

endpackage

// File: rtl/window_generator_line_buffer.sv
// One image row of pixel storage, indexed by column.
// Read is combinational so the old row value is seen before the write.
module line_buffer
    import img_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  pixel_t        wdata,
    output pixel_t        rdata
);

    pixel_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/window_generator.sv
// Turns a raster pixel stream into 3x3 windows with valid/ready flow control.
// Windows are emitted only where the full 3x3 neighbourhood lies inside the frame.
module window_generator
    import img_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic    clk,
    input  logic    rst_n,
    input  pixel_t  pix_data,
    input  logic    pix_valid,
    output logic    pix_ready,
    output window_t win_data,
    output logic    win_valid,
    input  logic    win_ready,
    output logic    frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    wg_state_t     state;
    wg_state_t     state_nxt;
    logic          xfer;
    logic          col_last;
    logic          row_last;
    logic          emit;
    pixel_t        lb1_q;
    pixel_t        lb2_q;
    window_t       win_q;

    assign pix_ready = !win_valid || win_ready;
    assign xfer      = pix_valid && pix_ready;
    assign col_last  = (col == CW'(IMG_W - 1));
    assign row_last  = (row == RW'(IMG_H - 1));

    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        unique case (state)
            FILL: begin
                if (xfer && col_last && row == RW'(1)) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                emit = xfer && (col >= CW'(2));
                if (xfer && col_last && row_last) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (xfer) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // A new window can replace the one leaving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= xfer && col_last && row_last;
            if (xfer) begin
                win_valid <= emit;
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

    line_buffer #(.DEPTH(IMG_W)) u_lb1 (
        .clk   (clk),
        .en    (xfer),
        .addr  (col),
        .wdata (pix_data),
        .rdata (lb1_q)
    );

    line_buffer #(.DEPTH(IMG_W)) u_lb2 (
        .clk   (clk),
        .en    (xfer),
        .addr  (col),
        .wdata (lb1_q),
        .rdata (lb2_q)
    );

    always_ff @(posedge clk) begin
        if (xfer) begin
            for (int i = 0; i < 3; i++) begin
                win_q[i][0] <= win_q[i][1];
                win_q[i][1] <= win_q[i][2];
            end
            win_q[0][2] <= lb2_q;
            win_q[1][2] <= lb1_q;
            win_q[2][2] <= pix_data;
        end
    end

    assign win_data = win_q;

endmodule

// File: tb/tb_window_generator.sv
// Bench for window_generator: scenario table plus directed stall/reset runs.
// Reference windows come from a whole-frame pixel array.
module tb_window_generator;
    import img_pkg::*;

    localparam int W = 8;
    localparam int H = 8;
    localparam int NWIN = (W - 2) * (H - 2);

    logic    clk = 1'b0;
    logic    rst_n;
    pixel_t  pix_data;
    logic    pix_valid;
    logic    pix_ready;
    window_t win_data;
    logic    win_valid;
    logic    win_ready = 1'b1;
    logic    frame_done;

    always #5 clk = ~clk;

    window_generator #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .win_data   (win_data),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .frame_done (frame_done)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    int stall_pct = 0;
    bit force_stall = 1'b0;
    int done_cnt  = 0;

    window_t exp_q[$];
    window_t got[$];
    pixel_t  img [H][W];
    int      mr = 0;
    int      mc = 0;
    bit      pend, pend_qual, pend_last, stalled;
    window_t held;

    typedef struct {
        int gap;
        int stall;
        bit rnd;
        int frames;
        int exp_win;
        int exp_done;
    } scen_t;

    scen_t tbl [6];

    task automatic check(input string name, input logic [71:0] act,
                         input logic [71:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic window_t ref_win(input int r, input int c);
        window_t w;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[i][j] = img[r-2+i][c-2+j];
        return w;
    endfunction

    function automatic window_t raster_win(input int r, input int c);
        window_t w;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[i][j] = pixel_t'((r - 2 + i) * W + (c - 2 + j) + 1);
        return w;
    endfunction

    always @(posedge clk) begin
        #1;
        win_ready = force_stall ? 1'b0 :
                    ($urandom_range(0, 99) >= stall_pct);
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_win_valid", win_valid, 0);
            check("rst_frame_done", frame_done, 0);
            check("rst_pix_ready", pix_ready, 1);
            mr = 0;
            mc = 0;
            pend = 0;
            stalled = 0;
            exp_q.delete();
        end else begin
            if (pend) begin
                check("win_valid_latency", win_valid, pend_qual);
                check("frame_done_pulse", frame_done, pend_last);
            end else begin
                check("frame_done_idle", frame_done, 0);
            end
            if (stalled) begin
                check("hold_valid", win_valid, 1);
                check("hold_data", win_data, held);
            end
            check("pix_ready_rule", pix_ready, !win_valid || win_ready);
            if (win_valid && win_ready) begin
                if (exp_q.size() == 0) check("unexpected_window", exp_q.size(), 1);
                else check("win_data", win_data, exp_q.pop_front());
                got.push_back(win_data);
            end
            if (frame_done) done_cnt++;
            stalled = win_valid && !win_ready;
            held = win_data;
            pend = pix_valid && pix_ready;
            if (pend) begin
                img[mr][mc] = pix_data;
                pend_qual = (mr >= 2 && mc >= 2);
                pend_last = (mr == H - 1 && mc == W - 1);
                if (pend_qual) exp_q.push_back(ref_win(mr, mc));
                if (mc == W - 1) begin
                    mc = 0;
                    mr = (mr == H - 1) ? 0 : mr + 1;
                end else begin
                    mc++;
                end
            end
        end
    end

    task automatic send_pix(input pixel_t v, input int gap_pct);
        int n;
        bit acc;
        while ($urandom_range(0, 99) < gap_pct) begin
            pix_valid = 1'b0;
            @(posedge clk); #1;
        end
        pix_valid = 1'b1;
        pix_data  = v;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 500) begin
            @(negedge clk);
            acc = pix_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) check("pix_accept_timeout", acc, 1);
        pix_valid = 1'b0;
    endtask

    task automatic send_frame(input int npix, input int gap_pct, input bit rnd);
        for (int p = 0; p < npix; p++)
            send_pix(rnd ? pixel_t'($urandom) : pixel_t'(p + 1), gap_pct);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pix_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b1;
    endtask

    task automatic check_seq(input int base, input int nwin);
        int k2;
        check("seq_count", got.size() - base, nwin);
        for (int k = 0; k < nwin && base + k < got.size(); k++) begin
            k2 = k % NWIN;
            check("seq_window", got[base + k],
                  raster_win(2 + k2 / (W - 2), 2 + k2 % (W - 2)));
        end
    endtask

    initial begin
        int base;
        int dbase;
        int n;
        bit seen;

        rst_n = 1'b0;
        pix_valid = 1'b0;
        pix_data = '0;

        tbl[0] = '{gap: 0,  stall: 0,  rnd: 0, frames: 1, exp_win: 36, exp_done: 1};
        tbl[1] = '{gap: 50, stall: 0,  rnd: 0, frames: 1, exp_win: 36, exp_done: 1};
        tbl[2] = '{gap: 0,  stall: 50, rnd: 1, frames: 1, exp_win: 36, exp_done: 1};
        tbl[3] = '{gap: 30, stall: 30, rnd: 1, frames: 2, exp_win: 72, exp_done: 2};
        tbl[4] = '{gap: 0,  stall: 0,  rnd: 0, frames: 2, exp_win: 72, exp_done: 2};
        tbl[5] = '{gap: 70, stall: 80, rnd: 1, frames: 1, exp_win: 36, exp_done: 1};

        @(negedge clk);
        check("init_win_valid", win_valid, 0);
        check("init_pix_ready", pix_ready, 1);

        for (int s = 0; s < 6; s++) begin
            do_reset();
            stall_pct = tbl[s].stall;
            base  = got.size();
            dbase = done_cnt;
            for (int f = 0; f < tbl[s].frames; f++)
                send_frame(W * H, tbl[s].gap, tbl[s].rnd);
            drain();
            stall_pct = 0;
            check("win_count", got.size() - base, tbl[s].exp_win);
            check("frame_done_count", done_cnt - dbase, tbl[s].exp_done);
            if (!tbl[s].rnd) check_seq(base, tbl[s].exp_win);
        end

        // Hold the downstream off for 5 cycles once windows start.
        do_reset();
        base = got.size();
        fork
            send_frame(W * H, 0, 0);
            begin
                n = 0;
                seen = 1'b0;
                while (!seen && n < 300) begin
                    @(negedge clk);
                    seen = win_valid;
                    n++;
                end
                if (!seen) check("stall_wait", seen, 1);
                force_stall = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_pix_ready", pix_ready, 0);
                    check("stall_win_valid", win_valid, 1);
                end
                force_stall = 1'b0;
            end
        join
        drain();
        check_seq(base, NWIN);

        // Reset part way through a frame, then a clean frame.
        do_reset();
        stall_pct = 20;
        send_frame(30, 20, 0);
        do_reset();
        base  = got.size();
        dbase = done_cnt;
        send_frame(W * H, 20, 0);
        drain();
        stall_pct = 0;
        check_seq(base, NWIN);
        check("rst_frame_done_count", done_cnt - dbase, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
